// File: rtl/muldiv_unit.sv
// Multi-cycle radix-2 multiply / restoring divide unit with HI/LO result registers.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier is zero.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W = WIDTH;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, neg_q, rneg_q, dbz_q;
  logic             done_q, dbz_out_q;
  logic [W-1:0]     hi_q, lo_q;
  logic [2*W-1:0]   acc_q, mcand_q;
  logic [W-1:0]     b_q;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic           x_neg, y_neg, start_ok, start_dbz, early, ge;
  logic [W-1:0]   x_mag, y_mag, fix_hi, fix_lo;
  logic [W:0]     rem_sh, trial;
  logic [2*W-1:0] acc_mul, acc_div, prod_fix;

  always_comb begin
    x_neg     = op[0] & x[W-1];
    y_neg     = op[0] & y[W-1];
    x_mag     = neg_w(x, x_neg);
    y_mag     = neg_w(y, y_neg);
    start_ok  = (state_q == IDLE) & start & ~flush;
    start_dbz = op[1] & (y == '0);
    early     = EARLY_OUT & ~is_div_q & (b_q == '0);
    acc_mul   = b_q[0] ? (acc_q + mcand_q) : acc_q;
    // Restoring step: the bit shifted out of rem is kept so the trial never overflows.
    rem_sh    = acc_q[2*W-1:W-1];
    trial     = rem_sh - {1'b0, mcand_q[W-1:0]};
    ge        = ~trial[W];
    acc_div   = {(ge ? trial[W-1:0] : rem_sh[W-1:0]), acc_q[W-2:0], ge};
    prod_fix  = neg_2w(acc_q, neg_q);
    if (dbz_q) begin
      fix_hi = acc_q[W-1:0];
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_hi = neg_w(acc_q[2*W-1:W], rneg_q);
      fix_lo = neg_w(acc_q[W-1:0], neg_q);
    end else begin
      fix_hi = prod_fix[2*W-1:W];
      fix_lo = prod_fix[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_ok) begin
          is_div_q <= op[1];
          neg_q    <= x_neg ^ y_neg;
          rneg_q   <= x_neg;
          dbz_q    <= start_dbz;
          // A zero divisor does no arithmetic but still spends one cycle before FIX.
          cnt_q    <= start_dbz ? CNT_W'(1) : CNT_W'(W);
          state_q  <= CALC;
        end
        CALC: if (flush) begin
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1) || early) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush) begin
            hi_q      <= fix_hi;
            lo_q      <= fix_lo;
            done_q    <= 1'b1;
            dbz_out_q <= dbz_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: operand load on accept, one shift-add or shift-subtract per CALC cycle.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      acc_q   <= op[1] ? {{W{1'b0}}, (start_dbz ? x : x_mag)} : '0;
      mcand_q <= {{W{1'b0}}, (op[1] ? y_mag : x_mag)};
      b_q     <= y_mag;
    end else if (state_q == CALC && !dbz_q && !early) begin
      if (is_div_q) begin
        acc_q <= acc_div;
      end else begin
        acc_q   <= acc_mul;
        mcand_q <= mcand_q << 1;
        b_q     <= b_q >> 1;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): directed vectors, monitor checks hi/lo/flag/latency.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, flush;
  logic [1:0]   op;
  logic [W-1:0] x, y;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           iss;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual hi=%0h lo=%0h required no done pulse", hi, lo);
      end else begin
        m_e = sb.pop_front();
        chk("hi", 64'(hi), 64'(m_e.hi));
        chk("lo", 64'(lo), 64'(m_e.lo));
        chk("div_by_zero", 64'(dbz), 64'(m_e.dbz));
        chk("latency", 64'(cyc - m_e.iss - 1), 64'(m_e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed, input int lat);
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed; e.lat = lat; e.iss = cyc;
    sb.push_back(e);
    op = o; x = a; y = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 64'(done), 64'd1);
  endtask

  task automatic abort_seq(input bit use_reset);
    op = 2'b10; x = 32'd1000; y = 32'd3; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (c == 5) begin x = 32'd77; y = 32'd5; end
      if (c == 10) begin
        if (use_reset) rst_n = 1'b0;
        else flush = 1'b1;
      end
    end
    if (use_reset) begin
      #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_hi", 64'(hi), 64'd0);
      chk("rst_mid_lo", 64'(lo), 64'd0);
      chk("rst_mid_dbz", 64'(dbz), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_hi_kept", 64'(hi), 64'd0);
      chk("flush_lo_kept", 64'(lo), 64'h2A);
    end
    repeat (40) @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; x = '0; y = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(dbz), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(100);
    chk("busy_in_done_cycle", 64'(busy), 64'd0);

    issue(2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
    wait_done(100);
    issue(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    wait_done(100);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33);
    wait_done(100);
    issue(2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
    wait_done(100);
    issue(2'b11, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0, 33);
    wait_done(100);

    issue(2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 2);
    wait_done(100);
    issue(2'b10, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33);
    wait_done(100);
    issue(2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2);
    wait_done(100);

    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
    wait_done(100);

    issue(2'b00, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 1'b0, 33);
    repeat (2) @(negedge clk);
    op = 2'b10; x = 32'd100; y = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    repeat (40) @(negedge clk);

    abort_seq(1'b0);
    abort_seq(1'b1);

    op = 2'b00; x = 32'd3; y = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_beats_start_lo", 64'(lo), 64'd0);

    issue(2'b00, 32'd7, 32'd3, 32'h00000000, 32'h00000015, 1'b0, EO ? 4 : 33);
    wait_done(100);
    issue(2'b00, 32'd5, 32'd0, 32'h00000000, 32'h00000000, 1'b0, EO ? 2 : 33);
    wait_done(100);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
